// File: rtl/display_value_formatter.sv
// display_value_formatter: turns a 16-bit debug value into four 4-bit digit
// codes for seven_segment_driver. It supports a hex mode and a decimal mode.
// Decimal mode uses a double-dabble engine that converts one bit per cycle.
// The input is resampled on a period timer or on request, and dig/ovf change
// only on the update_done cycle.
module display_value_formatter #(
   parameter int unsigned SAMPLE_CYCLES = 10_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] value,
   input  logic        dec_mode,
   input  logic        update_req,
   output logic [3:0]  dig [4],
   output logic        ovf,
   output logic        busy,
   output logic        update_done
);

   localparam int unsigned CNT_W = $clog2(SAMPLE_CYCLES);

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  timer_q;
   logic              sample_tick;
   logic              capture;
   logic              dec_load;
   logic              hex_load;
   logic              last_iter;
   logic [31:0]       work_q, work_d;
   logic [15:0]       bcd_adj;
   logic              over_q, over_d;
   logic [3:0]        bit_cnt_q;
   logic [15:0]       val_q;
   logic [15:0]       dec_digits;
   logic              dec_ovf;

   assign sample_tick = (timer_q == CNT_W'(SAMPLE_CYCLES - 1));
   assign capture     = (sample_tick | update_req) && (state_q == IDLE);

   // Sample period timer: free-running, wraps on its tick, restarts on every capture
   always_ff @(posedge clk) begin
      if (!reset_n)
         timer_q <= '0;
      else if (capture || sample_tick)
         timer_q <= '0;
      else
         timer_q <= timer_q + CNT_W'(1);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture && dec_mode) state_d = CONVERT;
         CONVERT: if (bit_cnt_q == 4'd15) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      busy      = (state_q == CONVERT);
      last_iter = (state_q == CONVERT) && (bit_cnt_q == 4'd15);
      dec_load  = capture && dec_mode;
      hex_load  = capture && !dec_mode;
   end

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
   always_comb begin
      bcd_adj = work_q[31:16];
      for (int unsigned i = 0; i < 4; i++) begin
         if (work_q[16 + 4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = work_q[16 + 4*i +: 4] + 4'd3;
      end
      work_d = {bcd_adj[14:0], work_q[15:0], 1'b0};
      over_d = over_q | bcd_adj[15];
   end

   // The commit values come from the final step's result, so dig is loaded on the
   // same edge that enters COMMIT and becomes visible together with update_done.
   always_comb begin
      if (over_d || (val_q > 16'd9999)) begin
         dec_digits = 16'h9999;
         dec_ovf    = 1'b1;
      end else begin
         dec_digits = work_d[31:16];
         dec_ovf    = 1'b0;
      end
   end

   // Datapath: input latch, conversion register, and committed display outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         work_q      <= '0;
         over_q      <= 1'b0;
         bit_cnt_q   <= '0;
         val_q       <= '0;
         ovf         <= 1'b0;
         update_done <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) dig[i] <= '0;
      end else begin
         update_done <= 1'b0;
         if (capture) val_q <= value;
         if (dec_load) begin
            work_q    <= {16'h0000, value};
            over_q    <= 1'b0;
            bit_cnt_q <= '0;
         end
         if (hex_load) begin
            for (int unsigned i = 0; i < 4; i++) dig[i] <= value[4*i +: 4];
            ovf         <= 1'b0;
            update_done <= 1'b1;
         end
         if (busy) begin
            work_q    <= work_d;
            over_q    <= over_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
         if (last_iter) begin
            for (int unsigned i = 0; i < 4; i++) dig[i] <= dec_digits[4*i +: 4];
            ovf         <= dec_ovf;
            update_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_value_formatter.sv
// Scoreboard bench for display_value_formatter with a 32-cycle sample period.
// The stimulus side pushes the expected digits, ovf and done cycle for each
// capture. The monitor pops one entry on every update_done and compares it.
module tb_display_value_formatter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] value = '0;
   logic        dec_mode = 1'b0;
   logic        update_req = 1'b0;
   logic [3:0]  dig [4];
   logic        ovf;
   logic        busy;
   logic        update_done;

   typedef struct {
      logic [15:0] digs;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   display_value_formatter #(.SAMPLE_CYCLES(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .value       (value),
      .dec_mode    (dec_mode),
      .update_req  (update_req),
      .dig         (dig),
      .ovf         (ovf),
      .busy        (busy),
      .update_done (update_done)
   );

   always #5 clk = ~clk;

   // Cycle counter, read at negedges as the current cycle number
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] packed_dig();
      return {dig[3], dig[2], dig[1], dig[0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input logic [15:0] d, input logic o, input int c);
      exp_t e;
      e.digs = d; e.ovf = o; e.cyc = c;
      sb.push_back(e);
   endtask

   // Monitor: every update_done must match the next scoreboard entry
   always @(negedge clk) begin
      if (update_done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_update: got update_done at cycle %0d expected none, dig=%0h", cyc, packed_dig());
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("dig", 32'(packed_dig()), 32'(e.digs));
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; the capture happens at the end of cycle c
   task automatic req(input logic [15:0] v, input logic m, output int c);
      value = v; dec_mode = m; update_req = 1'b1; c = cyc;
      @(negedge clk);
      update_req = 1'b0;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic run_hex(input logic [15:0] v);
      int c, nb;
      req(v, 1'b0, c);
      push(v, 1'b0, c + 1);
      nb = 0;
      for (int i = 0; i < 2; i++) begin
         if (busy) nb++;
         @(negedge clk);
      end
      check("hex_busy_cycles", nb, 0);
   endtask

   task automatic run_dec(input logic [15:0] v, input logic [15:0] d, input logic o);
      int c, nb;
      req(v, 1'b1, c);
      push(d, o, c + 17);
      nb = 0;
      for (int i = 1; i <= 17; i++) begin
         if (busy) nb++;
         @(negedge clk);
      end
      check("dec_busy_cycles", nb, 16);
   endtask

   initial begin
      int c0, r0;
      repeat (3) @(negedge clk);
      check("rst_dig", 32'(packed_dig()), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(update_done), 0);
      reset_n = 1'b1;
      @(negedge clk);

      run_hex(16'hBEEF);
      run_dec(16'd1234,  16'h1234, 1'b0);
      run_dec(16'd0,     16'h0000, 1'b0);
      run_dec(16'd9999,  16'h9999, 1'b0);
      run_dec(16'd10000, 16'h9999, 1'b1);
      run_dec(16'd65535, 16'h9999, 1'b1);
      run_dec(16'd42,    16'h0042, 1'b0);

      // A mid-conversion request is dropped and the new value is ignored.
      // Timer ticks then sample 5555 (decimal), then 0x1F2E (hex).
      req(16'd4321, 1'b1, c0);
      push(16'h4321, 1'b0, c0 + 17);
      wait_until(c0 + 5);
      value = 16'd5555; update_req = 1'b1;
      @(negedge clk);
      update_req = 1'b0;
      push(16'h5555, 1'b0, c0 + 49);
      push(16'h5555, 1'b0, c0 + 81);
      wait_until(c0 + 70);
      dec_mode = 1'b0; value = 16'h1F2E;
      push(16'h1F2E, 1'b0, c0 + 97);
      push(16'h1F2E, 1'b0, c0 + 129);
      push(16'h1F2E, 1'b0, c0 + 161);
      wait_until(c0 + 165);

      // Reset at T+8 of a decimal conversion: nothing is committed
      req(16'd1234, 1'b1, r0);
      wait_until(r0 + 8);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_dig", 32'(packed_dig()), 0);
      check("midrst_ovf", 32'(ovf), 0);
      check("midrst_done", 32'(update_done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_dec(16'd42, 16'h0042, 1'b0);
      run_hex(16'h0042);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish by cycle %0d expected finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
